// File: rtl/serial_mem_responder.sv
// serial_mem_responder
// Memory-side end of the bit-serial fetch link. An address arrives one bit
// per cycle while addr_valid is high. The addressed word from an internal
// writable store is then returned one bit per cycle, starting in the cycle
// right after the last address bit. A separate write port fills the store.
module serial_mem_responder #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              sys_clk,
    input  logic              sys_reset,
    input  logic              addr_valid,
    input  logic              addr_stream,
    output logic              data_stream,
    output logic              data_valid,
    output logic              busy,
    output logic              frame_err,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int MAX_W        = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W        = $clog2(MAX_W + 1);
    localparam int DEPTH        = 2 ** ADDR_W;
    localparam bit ONE_BIT_ADDR = (ADDR_W == 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RX_ADDR = 2'd1,
        ST_TX_DATA = 2'd2
    } state_t;

    // The new address bit enters at the end that ends up holding the last
    // transmitted bit, so after ADDR_W shifts the register holds the address.
    function automatic logic [ADDR_W-1:0] f_addr_shift(
        input logic [ADDR_W-1:0] base,
        input logic              bit_in
    );
        logic [ADDR_W-1:0] res;
        if (MSB_FIRST) begin
            res = (base << 1'b1) | ADDR_W'(bit_in);
        end else begin
            res = (base >> 1'b1) | (ADDR_W'(bit_in) << (ADDR_W - 1));
        end
        return res;
    endfunction

    // Bit of a word that goes on the wire next.
    function automatic logic f_tx_bit(input logic [DATA_W-1:0] word);
        logic res;
        if (MSB_FIRST) begin
            res = word[DATA_W-1];
        end else begin
            res = word[0];
        end
        return res;
    endfunction

    // Word with its outgoing bit removed.
    function automatic logic [DATA_W-1:0] f_tx_shift(input logic [DATA_W-1:0] word);
        logic [DATA_W-1:0] res;
        if (MSB_FIRST) begin
            res = word << 1'b1;
        end else begin
            res = word >> 1'b1;
        end
        return res;
    endfunction

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr_sr;
    logic [DATA_W-1:0] r_tx_sr;
    logic              r_data_stream;
    logic              r_data_valid;
    logic              r_busy;
    logic              r_frame_err;

    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] w_tx_nxt;
    logic              w_dout_nxt;
    logic              w_dval_nxt;
    logic              w_ferr_nxt;

    logic [ADDR_W-1:0] w_addr_base;
    logic [ADDR_W-1:0] w_addr_full;
    logic [DATA_W-1:0] w_rd_word;
    logic              w_last_bit;

    // A fresh frame starts from an empty shift register; mid-frame the
    // collected bits are the base. The full address includes the current bit.
    assign w_addr_base = (r_state == ST_RX_ADDR) ? r_addr_sr : {ADDR_W{1'b0}};
    assign w_addr_full = f_addr_shift(w_addr_base, addr_stream);
    // Read is combinational; a same-edge write lands afterwards, so a
    // colliding lookup sees the old word.
    assign w_rd_word   = r_mem[w_addr_full];
    assign w_last_bit  = (r_state == ST_IDLE) ? ONE_BIT_ADDR
                                              : (r_cnt == CNT_W'(ADDR_W - 1));

    // Store write port; contents deliberately survive reset.
    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Next-state and next-output logic of the frame FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr_sr;
        w_tx_nxt    = r_tx_sr;
        w_dout_nxt  = 1'b0;
        w_dval_nxt  = 1'b0;
        w_ferr_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (addr_valid) begin
                    w_addr_nxt = w_addr_full;
                    if (w_last_bit) begin
                        w_state_nxt = ST_TX_DATA;
                        w_cnt_nxt   = CNT_W'(1);
                        w_dout_nxt  = f_tx_bit(w_rd_word);
                        w_dval_nxt  = 1'b1;
                        w_tx_nxt    = f_tx_shift(w_rd_word);
                    end else begin
                        w_state_nxt = ST_RX_ADDR;
                        w_cnt_nxt   = CNT_W'(1);
                    end
                end else begin
                    w_cnt_nxt = {CNT_W{1'b0}};
                end
            end
            ST_RX_ADDR: begin
                if (addr_valid) begin
                    w_addr_nxt = w_addr_full;
                    if (w_last_bit) begin
                        w_state_nxt = ST_TX_DATA;
                        w_cnt_nxt   = CNT_W'(1);
                        w_dout_nxt  = f_tx_bit(w_rd_word);
                        w_dval_nxt  = 1'b1;
                        w_tx_nxt    = f_tx_shift(w_rd_word);
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end else begin
                    // Address cut short: abandon the frame and flag it.
                    w_ferr_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end
            end
            ST_TX_DATA: begin
                // Address activity while transmitting is flagged but ignored.
                w_ferr_nxt = addr_valid;
                if (r_cnt == CNT_W'(DATA_W)) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else begin
                    w_dout_nxt = f_tx_bit(r_tx_sr);
                    w_dval_nxt = 1'b1;
                    w_tx_nxt   = f_tx_shift(r_tx_sr);
                    w_cnt_nxt  = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, datapath and registered outputs; async reset clears everything.
    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= {CNT_W{1'b0}};
            r_addr_sr     <= {ADDR_W{1'b0}};
            r_tx_sr       <= {DATA_W{1'b0}};
            r_data_stream <= 1'b0;
            r_data_valid  <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_addr_sr     <= w_addr_nxt;
            r_tx_sr       <= w_tx_nxt;
            r_data_stream <= w_dout_nxt;
            r_data_valid  <= w_dval_nxt;
            r_busy        <= (w_state_nxt != ST_IDLE);
            r_frame_err   <= w_ferr_nxt;
        end
    end

    assign data_stream = r_data_stream;
    assign data_valid  = r_data_valid;
    assign busy        = r_busy;
    assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_serial_mem_responder.sv
// Directed bench for serial_mem_responder: one MSB-first and one LSB-first
// instance share a clock and reset; sel_lsb routes stimulus and observation.
module tb_serial_mem_responder;

    logic        sys_clk = 1'b0;
    logic        sys_reset;
    logic        addr_valid;
    logic        addr_stream;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        sel_lsb;

    logic m_ds, m_dv, m_busy, m_ferr;
    logic l_ds, l_dv, l_busy, l_ferr;
    logic data_stream, data_valid, busy, frame_err;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 sys_clk = ~sys_clk;

    serial_mem_responder #(.ADDR_W(8), .DATA_W(16), .MSB_FIRST(1'b1)) u_dut_msb (
        .sys_clk     (sys_clk),
        .sys_reset   (sys_reset),
        .addr_valid  (addr_valid & ~sel_lsb),
        .addr_stream (addr_stream),
        .data_stream (m_ds),
        .data_valid  (m_dv),
        .busy        (m_busy),
        .frame_err   (m_ferr),
        .wr_en       (wr_en & ~sel_lsb),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data)
    );

    serial_mem_responder #(.ADDR_W(8), .DATA_W(16), .MSB_FIRST(1'b0)) u_dut_lsb (
        .sys_clk     (sys_clk),
        .sys_reset   (sys_reset),
        .addr_valid  (addr_valid & sel_lsb),
        .addr_stream (addr_stream),
        .data_stream (l_ds),
        .data_valid  (l_dv),
        .busy        (l_busy),
        .frame_err   (l_ferr),
        .wr_en       (wr_en & sel_lsb),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data)
    );

    assign data_stream = sel_lsb ? l_ds   : m_ds;
    assign data_valid  = sel_lsb ? l_dv   : m_dv;
    assign busy        = sel_lsb ? l_busy : m_busy;
    assign frame_err   = sel_lsb ? l_ferr : m_ferr;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic mem_write(input logic [7:0] a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    // Sends all 8 address bits; optionally writes wd to the same address
    // in the cycle the last bit is sampled.
    task automatic send_addr(input logic [7:0] a, input bit wr_last, input logic [15:0] wd);
        for (int i = 0; i < 8; i++) begin
            addr_valid  = 1'b1;
            addr_stream = sel_lsb ? a[i] : a[7-i];
            if (wr_last && i == 7) begin
                wr_en   = 1'b1;
                wr_addr = a;
                wr_data = wd;
            end
            step();
        end
        wr_en       = 1'b0;
        addr_valid  = 1'b0;
        addr_stream = 1'b0;
    endtask

    // Collects 16 data cycles starting now; optionally raises addr_valid
    // for one cycle at index pulse_at.
    task automatic recv_word(input int pulse_at, output logic [15:0] w,
                             output int nvalid, output int nerr);
        w      = 16'h0000;
        nvalid = 0;
        nerr   = 0;
        for (int k = 0; k < 16; k++) begin
            addr_valid = (k == pulse_at);
            if (data_valid) nvalid++;
            if (frame_err) nerr++;
            if (sel_lsb) w[k] = data_stream;
            else         w    = {w[14:0], data_stream};
            step();
        end
        addr_valid = 1'b0;
        if (frame_err) nerr++;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] w;
        int          nv;
        int          ne;

        sys_reset   = 1'b0;
        addr_valid  = 1'b0;
        addr_stream = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = 8'h00;
        wr_data     = 16'h0000;
        sel_lsb     = 1'b0;
        step();
        step();
        check_val("reset outs", {m_ds, m_dv, m_busy, m_ferr, l_ds, l_dv, l_busy, l_ferr}, 32'h0);
        sys_reset = 1'b1;
        step();
        check_val("idle busy", busy, 32'h0);

        // T1: basic MSB-first fetch
        mem_write(8'hA5, 16'hBEEF);
        send_addr(8'hA5, 1'b0, 16'h0000);
        check_val("T1 first dv", data_valid, 32'h1);
        check_val("T1 busy", busy, 32'h1);
        recv_word(-1, w, nv, ne);
        check_val("T1 word", w, 32'hBEEF);
        check_val("T1 nvalid", nv, 32'd16);
        check_val("T1 nerr", ne, 32'd0);
        check_val("T1 dv after", data_valid, 32'h0);
        check_val("T1 busy after", busy, 32'h0);

        // T2: boundary addresses, back-to-back frames
        mem_write(8'h00, 16'h0001);
        mem_write(8'hFF, 16'h8000);
        send_addr(8'h00, 1'b0, 16'h0000);
        recv_word(-1, w, nv, ne);
        check_val("T2 word0", w, 32'h0001);
        check_val("T2 nvalid0", nv, 32'd16);
        send_addr(8'hFF, 1'b0, 16'h0000);
        recv_word(-1, w, nv, ne);
        check_val("T2 wordFF", w, 32'h8000);
        check_val("T2 nvalidFF", nv, 32'd16);

        // T3: truncated address
        for (int i = 0; i < 5; i++) begin
            addr_valid  = 1'b1;
            addr_stream = (i % 2 == 0) ? 1'b1 : 1'b0;
            step();
        end
        addr_valid = 1'b0;
        check_val("T3 busy mid", busy, 32'h1);
        step();
        check_val("T3 ferr", frame_err, 32'h1);
        check_val("T3 dv", data_valid, 32'h0);
        check_val("T3 ds", data_stream, 32'h0);
        check_val("T3 busy", busy, 32'h0);
        step();
        check_val("T3 ferr one cycle", frame_err, 32'h0);
        check_val("T3 dv later", data_valid, 32'h0);
        send_addr(8'hA5, 1'b0, 16'h0000);
        recv_word(-1, w, nv, ne);
        check_val("T3 word", w, 32'hBEEF);

        // T4: write collides with lookup
        send_addr(8'hA5, 1'b1, 16'h1234);
        recv_word(-1, w, nv, ne);
        check_val("T4 old word", w, 32'hBEEF);
        send_addr(8'hA5, 1'b0, 16'h0000);
        recv_word(-1, w, nv, ne);
        check_val("T4 new word", w, 32'h1234);

        // T5: async reset mid transmit
        send_addr(8'hA5, 1'b0, 16'h0000);
        for (int k = 0; k < 7; k++) step();
        check_val("T5 dv before", data_valid, 32'h1);
        #2;
        sys_reset = 1'b0;
        #1;
        check_val("T5 outs in reset", {data_stream, data_valid, busy, frame_err}, 32'h0);
        step();
        sys_reset = 1'b1;
        step();
        check_val("T5 ferr after", frame_err, 32'h0);
        send_addr(8'hA5, 1'b0, 16'h0000);
        recv_word(-1, w, nv, ne);
        check_val("T5 word", w, 32'h1234);
        check_val("T5 nvalid", nv, 32'd16);

        // T6: LSB-first instance, stray addr_valid during transmit
        sel_lsb = 1'b1;
        mem_write(8'h01, 16'h0003);
        send_addr(8'h01, 1'b0, 16'h0000);
        check_val("T6 first bit", data_stream, 32'h1);
        recv_word(4, w, nv, ne);
        check_val("T6 word", w, 32'h0003);
        check_val("T6 nvalid", nv, 32'd16);
        check_val("T6 nerr", ne, 32'd1);
        check_val("T6 dv after", data_valid, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
